// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pkg
// Description : Shared constants for the instruction fetch unit: FSM state
//               encodings, memory response codes, the nop used to replace
//               faulting fetches, and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package ifu_pkg;

    // FSM state encodings
    localparam logic [1:0]  c_ST_IDLE = 2'd0;
    localparam logic [1:0]  c_ST_REQ  = 2'd1;
    localparam logic [1:0]  c_ST_WAIT = 2'd2;
    localparam logic [1:0]  c_ST_HOLD = 2'd3;

    // Memory read response OKAY
    localparam logic [1:0]  c_RESP_OKAY = 2'b00;

    // addi x0, x0, 0
    localparam logic [31:0] c_NOP_INST = 32'h0000_0013;

    // Default PC loaded at reset
    localparam logic [31:0] c_RST_PC_DEFAULT = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/ifu_pc.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc
// Description : Program counter register for the fetch unit. Loads RST_PC on
//               reset, takes a word-aligned redirect target (low two bits
//               forced to zero) with priority over the +4 increment, which
//               wraps modulo 2^DATA_LEN. pc_next exposes the value the
//               register takes at the coming edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc
    import ifu_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_PC   = DATA_LEN'(c_RST_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                inc_en,
    input  logic                load_en,
    input  logic [DATA_LEN-1:0] load_addr,
    output logic [DATA_LEN-1:0] pc,
    output logic [DATA_LEN-1:0] pc_next
);

    localparam logic [DATA_LEN-1:0] c_ALIGN_MASK = ~DATA_LEN'(3);
    localparam logic [DATA_LEN-1:0] c_PC_STEP    = DATA_LEN'(4);

    logic [DATA_LEN-1:0] r_pc;
    logic [DATA_LEN-1:0] w_pc_next;

    // Next PC: redirect wins over increment, otherwise hold
    always_comb begin
        w_pc_next = r_pc;
        if (load_en) begin
            w_pc_next = load_addr & c_ALIGN_MASK;
        end else if (inc_en) begin
            w_pc_next = r_pc + c_PC_STEP;
        end
    end

    // PC register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= RST_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc      = r_pc;
    assign pc_next = w_pc_next;

endmodule
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// Module      : ifu
// Description : Instruction fetch unit. Issues one read at a time on a
//               valid/ready address/data channel pair, hands each fetched
//               word with its PC to decode over valid/ready, handles
//               redirects (dropping in-flight data) and a halt level.
//               Optional feature macro: IFU_ACCESS_FAULT_EN adds the
//               inst_fault output and replaces faulting fetches with a nop.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu
    import ifu_pkg::*;
#(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RST_PC   = DATA_LEN'(c_RST_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                ifu_arvalid,
    input  logic                ifu_arready,
    output logic [DATA_LEN-1:0] ifu_araddr,
    input  logic                ifu_rvalid,
    output logic                ifu_rready,
    input  logic [31:0]         ifu_rdata,
    input  logic [1:0]          ifu_rresp,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [DATA_LEN-1:0] inst_pc,
`ifdef IFU_ACCESS_FAULT_EN
    output logic                inst_fault,
`endif
    input  logic                jump_flag,
    input  logic [DATA_LEN-1:0] jump_addr,
    input  logic                halt
);

    logic [1:0]          r_state;
    logic                r_drop;
    logic                r_arvalid;
    logic [DATA_LEN-1:0] r_araddr;
    logic                r_rready;
    logic                r_inst_valid;
    logic [31:0]         r_inst;
    logic [DATA_LEN-1:0] r_inst_pc;

    logic [1:0]          w_state_next;
    logic                w_drop_next;
    logic                w_capture;
    logic                w_pc_inc;
    logic [DATA_LEN-1:0] w_pc;
    logic [DATA_LEN-1:0] w_pc_next;

    // PC advances only on a real acceptance; a redirect in the same cycle squashes it
    assign w_pc_inc  = (r_state == c_ST_HOLD) && inst_ready && !jump_flag;
    // Data is kept only if no redirect is pending or arriving
    assign w_capture = (r_state == c_ST_WAIT) && ifu_rvalid && !jump_flag && !r_drop;

    ifu_pc #(
        .DATA_LEN (DATA_LEN),
        .RST_PC   (RST_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en    (w_pc_inc),
        .load_en   (jump_flag),
        .load_addr (jump_addr),
        .pc        (w_pc),
        .pc_next   (w_pc_next)
    );

    // Next-state and drop-flag decision; redirects take priority
    always_comb begin
        w_state_next = r_state;
        w_drop_next  = r_drop;
        case (r_state)
            c_ST_IDLE: begin
                if (!halt) w_state_next = c_ST_REQ;
            end
            c_ST_REQ: begin
                // The address in flight must stay stable, so a redirect only marks it stale
                if (jump_flag)   w_drop_next  = 1'b1;
                if (ifu_arready) w_state_next = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (ifu_rvalid) begin
                    if (jump_flag || r_drop) begin
                        w_drop_next  = 1'b0;
                        w_state_next = halt ? c_ST_IDLE : c_ST_REQ;
                    end else begin
                        w_state_next = c_ST_HOLD;
                    end
                end else if (jump_flag) begin
                    w_drop_next = 1'b1;
                end
            end
            c_ST_HOLD: begin
                if (jump_flag || inst_ready) w_state_next = halt ? c_ST_IDLE : c_ST_REQ;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

`ifdef IFU_ACCESS_FAULT_EN
    logic r_fault;
`else
    // Response status has no effect without the fault feature
    logic w_unused_rresp;
    assign w_unused_rresp = ^ifu_rresp;
`endif

    // State register and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_drop       <= 1'b0;
            r_arvalid    <= 1'b0;
            r_araddr     <= '0;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
`ifdef IFU_ACCESS_FAULT_EN
            r_fault      <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_drop       <= w_drop_next;
            r_arvalid    <= (w_state_next == c_ST_REQ);
            r_rready     <= (w_state_next == c_ST_WAIT);
            r_inst_valid <= (w_state_next == c_ST_HOLD);
            // Address is captured on entry to REQ and held until the handshake
            if ((r_state != c_ST_REQ) && (w_state_next == c_ST_REQ)) begin
                r_araddr <= w_pc_next;
            end
            if (w_capture) begin
                r_inst_pc <= w_pc;
`ifdef IFU_ACCESS_FAULT_EN
                if (ifu_rresp != c_RESP_OKAY) begin
                    r_inst  <= c_NOP_INST;
                    r_fault <= 1'b1;
                end else begin
                    r_inst  <= ifu_rdata;
                    r_fault <= 1'b0;
                end
`else
                r_inst    <= ifu_rdata;
`endif
            end
        end
    end

    assign ifu_arvalid = r_arvalid;
    assign ifu_araddr  = r_araddr;
    assign ifu_rready  = r_rready;
    assign inst_valid  = r_inst_valid;
    assign inst        = r_inst;
    assign inst_pc     = r_inst_pc;
`ifdef IFU_ACCESS_FAULT_EN
    assign inst_fault  = r_fault;
`endif

endmodule
`default_nettype wire
